// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle req/ack memory access stage that feeds IR/MDR and stalls the MIPS controller.
// Optional MEM_TIMEOUT_EN aborts a REQ that waits TIMEOUT cycles without ack. Rev 1.0.
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              iord_i,
  input  logic              mem_write_i,
  input  logic              instr_latch_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [5:0]        op_o,
  output logic [5:0]        funct_o,
  output logic [DATA_W-1:0] mdr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fault_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              il_q, il_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] req_addr;
  logic              timeout_hit;

  assign req_addr = iord_i ? alu_out_i : pc_i;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed REQ cycles without ack; the TIMEOUT-th such cycle aborts.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start_i) begin
      cnt_d = '0;
    end else if (state_q == S_REQ && !bus_ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = (req_addr[1:0] != 2'b00) ? S_ERR : S_REQ;
      S_REQ: begin
        if (bus_ack_i)        state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o = (state_q == S_REQ);
    bus_we_o  = we_q & (state_q == S_REQ);
    done_o    = (state_q == S_DONE) || (state_q == S_ERR);
    busy_o    = start_i || ((state_q != S_IDLE) && (state_q != S_DONE));
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    il_d    = il_q;
    instr_d = instr_q;
    mdr_d   = mdr_q;
    fault_d = fault_q;
    if (state_q == S_IDLE && start_i) begin
      addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      wdata_d = wd_i;
      we_d    = mem_write_i;
      il_d    = instr_latch_i;
    end
    if (state_q == S_REQ && bus_ack_i && !we_q) begin
      if (il_q) instr_d = bus_rdata_i;
      else      mdr_d   = bus_rdata_i;
    end
    // Raised on the edge that enters ERR so fault and done appear together.
    if (state_d == S_ERR) fault_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      il_q    <= 1'b0;
      instr_q <= '0;
      mdr_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      il_q    <= il_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      fault_q <= fault_d;
    end
  end

  assign instr_o     = instr_q;
  assign op_o        = instr_q[31:26];
  assign funct_o     = instr_q[5:0];
  assign mdr_o       = mdr_q;
  assign fault_o     = fault_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven access vectors plus directed corner sequences for mem_access_unit.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout abort (TIMEOUT=4). Rev 1.0.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, iord, mem_write, instr_latch;
  logic [31:0] pc, alu_out, wd;
  logic [31:0] instr, mdr, bus_addr, bus_wdata, bus_rdata;
  logic [5:0]  op, funct;
  logic        busy, done, fault, bus_req, bus_we, bus_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .iord_i(iord),
    .mem_write_i(mem_write), .instr_latch_i(instr_latch), .pc_i(pc),
    .alu_out_i(alu_out), .wd_i(wd), .instr_o(instr), .op_o(op), .funct_o(funct),
    .mdr_o(mdr), .busy_o(busy), .done_o(done), .fault_o(fault),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  typedef struct {
    logic        iord;
    logic        we;
    logic        il;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    int          dly;
    logic [31:0] rdata;
    logic        misal;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_mdr;
    logic [5:0]  exp_op;
    logic [5:0]  exp_funct;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int dc;
    //          iord we il  pc            alu           wd            dly rdata         mis addr          instr         mdr           op     funct
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h00000040, 32'h00000000, 32'h00000000, 3, 32'h8C220004, 1'b0, 32'h00000040, 32'h8C220004, 32'h00000000, 6'h23, 6'h04};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h00000044, 32'h00000100, 32'h00000000, 1, 32'hDEADBEEF, 1'b0, 32'h00000100, 32'h8C220004, 32'hDEADBEEF, 6'h23, 6'h04};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000200, 32'h12345678, 0, 32'hFFFFFFFF, 1'b0, 32'h00000200, 32'h8C220004, 32'hDEADBEEF, 6'h23, 6'h04};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000204, 32'hA5A5A5A5, 2, 32'h11111111, 1'b0, 32'h00000204, 32'h8C220004, 32'hDEADBEEF, 6'h23, 6'h04};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h00000044, 32'h00000000, 32'h00000000, 0, 32'h00851020, 1'b0, 32'h00000044, 32'h00851020, 32'hDEADBEEF, 6'h00, 6'h20};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h00000046, 32'h00000300, 32'h00000000, 4, 32'h0BADF00D, 1'b0, 32'h00000300, 32'h00851020, 32'h0BADF00D, 6'h00, 6'h20};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000202, 32'h00000000, 0, 32'h00000000, 1'b1, 32'h00000000, 32'h00851020, 32'h0BADF00D, 6'h00, 6'h20};

    rst_n = 1'b0; start = 1'b0; iord = 1'b0; mem_write = 1'b0; instr_latch = 1'b0;
    pc = '0; alu_out = '0; wd = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst instr", instr, 32'h0);
    chk("rst mdr", mdr, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst fault", fault, 1'b0);
    chk1("rst bus_req", bus_req, 1'b0);
    chk1("rst bus_we", bus_we, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b1; iord = vecs[i].iord; mem_write = vecs[i].we; instr_latch = vecs[i].il;
      pc = vecs[i].pc; alu_out = vecs[i].alu; wd = vecs[i].wd;
      #1 chk1($sformatf("v%0d busy@start", i), busy, 1'b1);
      @(negedge clk);
      start = 1'b0;
      if (vecs[i].misal) begin
        chk1($sformatf("v%0d bus_req", i), bus_req, 1'b0);
        chk1($sformatf("v%0d done", i), done, 1'b1);
      end else begin
        chk1($sformatf("v%0d bus_req", i), bus_req, 1'b1);
        chk($sformatf("v%0d bus_addr", i), bus_addr, vecs[i].exp_addr);
        chk1($sformatf("v%0d bus_we", i), bus_we, vecs[i].we);
        if (vecs[i].we) chk($sformatf("v%0d bus_wdata", i), bus_wdata, vecs[i].wd);
        chk1($sformatf("v%0d done early", i), done, 1'b0);
        for (int d = 0; d < vecs[i].dly; d++) begin
          @(negedge clk);
          chk1($sformatf("v%0d bus_req hold", i), bus_req, 1'b1);
        end
        bus_ack = 1'b1; bus_rdata = vecs[i].rdata;
        #1 chk1($sformatf("v%0d busy@ack", i), busy, 1'b1);
        @(negedge clk);
        bus_ack = 1'b0;
        chk1($sformatf("v%0d done", i), done, 1'b1);
        chk1($sformatf("v%0d bus_req off", i), bus_req, 1'b0);
        chk1($sformatf("v%0d busy off", i), busy, 1'b0);
      end
      chk($sformatf("v%0d instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("v%0d mdr", i), mdr, vecs[i].exp_mdr);
      chk($sformatf("v%0d op", i), 32'(op), 32'(vecs[i].exp_op));
      chk($sformatf("v%0d funct", i), 32'(funct), 32'(vecs[i].exp_funct));
      chk1($sformatf("v%0d fault", i), fault, vecs[i].misal);
      @(negedge clk);
      chk1($sformatf("v%0d done once", i), done, 1'b0);
    end

    // start while busy must not be queued or change the in-flight access
    @(negedge clk);
    start = 1'b1; iord = 1'b0; mem_write = 1'b0; instr_latch = 1'b1; pc = 32'h80;
    @(negedge clk);
    iord = 1'b1; mem_write = 1'b1; instr_latch = 1'b0; alu_out = 32'h400;
    #1 chk1("busy start busy", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("busy start addr", bus_addr, 32'h80);
    chk1("busy start we", bus_we, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h12340000;
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("busy start done", done, 1'b1);
    chk("busy start instr", instr, 32'h12340000);
    chk("busy start mdr", mdr, 32'h0BADF00D);
    @(negedge clk);
    chk1("no queued req", bus_req, 1'b0);
    chk1("no queued busy", busy, 1'b0);

    // ack while idle is ignored
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("idle ack instr", instr, 32'h12340000);
    chk("idle ack mdr", mdr, 32'h0BADF00D);
    chk1("idle ack done", done, 1'b0);

    // asynchronous reset in the middle of a request
    @(negedge clk);
    start = 1'b1; iord = 1'b0; mem_write = 1'b0; instr_latch = 1'b1; pc = 32'h90;
    @(negedge clk);
    start = 1'b0;
    chk1("midreq bus_req", bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("async bus_req", bus_req, 1'b0);
    chk("async instr", instr, 32'h0);
    chk("async mdr", mdr, 32'h0);
    chk("async bus_addr", bus_addr, 32'h0);
    chk("async bus_wdata", bus_wdata, 32'h0);
    chk1("async fault", fault, 1'b0);
    chk1("async done", done, 1'b0);
    chk1("async busy", busy, 1'b0);
    chk1("async bus_we", bus_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late ack instr", instr, 32'h0);
    chk("late ack mdr", mdr, 32'h0);
    chk1("late ack done", done, 1'b0);
    chk1("late ack bus_req", bus_req, 1'b0);

    // load that never sees an ack
    @(negedge clk);
    start = 1'b1; iord = 1'b1; mem_write = 1'b0; instr_latch = 1'b0; alu_out = 32'h500;
    @(negedge clk);
    start = 1'b0;
    rc = 0; dc = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_req) rc++;
      if (done) dc++;
      @(negedge clk);
    end
`ifdef MEM_TIMEOUT_EN
    chk("timeout req cycles", 32'(rc), 32'd4);
    chk("timeout done pulses", 32'(dc), 32'd1);
    chk1("timeout fault", fault, 1'b1);
    chk1("timeout bus_req", bus_req, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("timeout late mdr", mdr, 32'h0);
    chk1("timeout late done", done, 1'b0);
`else
    chk("wait req cycles", 32'(rc), 32'd20);
    chk("wait done pulses", 32'(dc), 32'd0);
    chk1("wait bus_req", bus_req, 1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk);
    bus_ack = 1'b0;
    chk1("wait done", done, 1'b1);
    chk("wait mdr", mdr, 32'h55555555);
    chk1("wait fault", fault, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
